// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: ID/EX operand resolution, forwarding, hazard stall and EX register.
// Define OPF_FORWARD_EN for EX/MEM/WB bypassing; otherwise every pending write to a used source stalls.
module operand_fetch_stage #(
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs1_index,
  input  logic [4:0]        id_rs2_index,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        id_rd_index,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [4:0]        rs1_index,
  output logic [4:0]        rs2_index,
  input  logic [31:0]       rs1_data_out,
  input  logic [31:0]       rs2_data_out,
  input  logic [31:0]       ex_fwd_data,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [4:0]        mem_rd_index,
  input  logic              mem_data_ready,
  input  logic [31:0]       mem_fwd_data,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd_index,
  input  logic [31:0]       wb_data,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_is_load,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_rs1_val,
  output logic [31:0]       ex_rs2_val,
  output logic [4:0]        ex_rd_index,
  output logic [CTRL_W-1:0] ex_ctrl
);
  logic [4:0]  idx [2];
  logic [31:0] rf  [2];
  logic [31:0] val [2];
  logic [1:0]  use_s, em, mm, wm, hz;
  logic        hazard;
  assign rs1_index = id_rs1_index;
  assign rs2_index = id_rs2_index;
  assign idx[0] = id_rs1_index;
  assign idx[1] = id_rs2_index;
  assign rf[0]  = rs1_data_out;
  assign rf[1]  = rs2_data_out;
  assign use_s  = {id_uses_rs2, id_uses_rs1};
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      em[s] = ex_valid & ex_reg_write & (ex_rd_index == idx[s]);
      mm[s] = mem_valid & mem_reg_write & (mem_rd_index == idx[s]);
      wm[s] = wb_en & (wb_rd_index == idx[s]);
`ifdef OPF_FORWARD_EN
      val[s] = (idx[s] == 5'd0) ? 32'd0 : em[s] ? ex_fwd_data : mm[s] ? mem_fwd_data : wm[s] ? wb_data : rf[s];
      // the youngest matching stage decides; an EX ALU result hides a stale MEM load
      hz[s] = use_s[s] & (idx[s] != 5'd0) & (em[s] ? ex_is_load : (mm[s] & ~mem_data_ready));
`else
      val[s] = (idx[s] == 5'd0) ? 32'd0 : rf[s];
      hz[s] = use_s[s] & (idx[s] != 5'd0) & (em[s] | mm[s] | wm[s]);
`endif
    end
  end
`ifndef OPF_FORWARD_EN
  logic unused_ok;
  assign unused_ok = ^{ex_fwd_data, mem_fwd_data, wb_data, mem_data_ready};
`endif
  assign hazard   = |hz;
  assign id_stall = ~rst & ~flush & (ex_hold | (id_valid & hazard));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_rd_index  <= '0;
      ex_ctrl      <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (!ex_hold) begin
      if (id_valid & hazard) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid     <= id_valid;
        ex_reg_write <= id_reg_write;
        ex_is_load   <= id_is_load;
        ex_pc        <= id_pc;
        ex_imm       <= id_imm;
        ex_rs1_val   <= val[0];
        ex_rs2_val   <= val[1];
        ex_rd_index  <= id_rd_index;
        ex_ctrl      <= id_ctrl;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed checks of forwarding, stalls, bubbles, flush, hold and async reset.
module tb_operand_fetch_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load;
  logic [31:0] id_pc, id_imm, rs1_data_out, rs2_data_out, ex_fwd_data, mem_fwd_data, wb_data;
  logic [4:0]  id_rs1_index, id_rs2_index, id_rd_index, mem_rd_index, wb_rd_index;
  logic [15:0] id_ctrl;
  logic        mem_valid, mem_reg_write, mem_data_ready, wb_en, ex_hold, flush;
  logic [4:0]  rs1_index, rs2_index, ex_rd_index;
  logic        id_stall, ex_valid, ex_reg_write, ex_is_load;
  logic [31:0] ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
  logic [15:0] ex_ctrl;
  int          errors = 0, checks = 0;
  always #5 clk = ~clk;
  operand_fetch_stage #(.CTRL_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd_index(id_rd_index), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .rs1_index(rs1_index), .rs2_index(rs2_index),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out), .ex_fwd_data(ex_fwd_data),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd_index(mem_rd_index),
    .mem_data_ready(mem_data_ready), .mem_fwd_data(mem_fwd_data), .wb_en(wb_en),
    .wb_rd_index(wb_rd_index), .wb_data(wb_data), .ex_hold(ex_hold), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_rd_index(ex_rd_index), .ex_ctrl(ex_ctrl)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_stall(input string tag, input logic exp);
    #1;
    chk(tag, {31'd0, id_stall}, {31'd0, exp});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    {id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load} = '0;
    {id_pc, id_imm, rs1_data_out, rs2_data_out, ex_fwd_data, mem_fwd_data, wb_data} = '0;
    {id_rs1_index, id_rs2_index, id_rd_index, mem_rd_index, wb_rd_index} = '0;
    id_ctrl = '0;
    {mem_valid, mem_reg_write, mem_data_ready, wb_en, ex_hold, flush} = '0;
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    clr();
  endtask
  task automatic issue(input logic [31:0] pc, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic ld);
    id_valid = 1'b1; id_pc = pc; id_imm = pc ^ 32'h5A; id_ctrl = pc[15:0];
    id_rs1_index = r1; id_uses_rs1 = u1; id_rs2_index = r2; id_uses_rs2 = u2;
    id_rd_index = rd; id_reg_write = rw; id_is_load = ld;
  endtask
  initial begin
    clr();
    ex_hold = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_stall", {31'd0, id_stall}, 32'd0);
    rst = 1'b0;
    ex_hold = 1'b0;
    // plain capture
    issue(32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    rs1_data_out = 32'h11; rs2_data_out = 32'h22;
    chk_stall("a_stall", 1'b0);
    chk("a_rs1_index", {27'd0, rs1_index}, 32'd1);
    chk("a_rs2_index", {27'd0, rs2_index}, 32'd2);
    tick();
    chk("a_valid", {31'd0, ex_valid}, 32'd1);
    chk("a_pc", ex_pc, 32'h100);
    chk("a_imm", ex_imm, 32'h15A);
    chk("a_rs1", ex_rs1_val, 32'h11);
    chk("a_rs2", ex_rs2_val, 32'h22);
    chk("a_rd", {27'd0, ex_rd_index}, 32'd3);
    chk("a_ctrl", {16'd0, ex_ctrl}, 32'h0100);
    // asynchronous reset mid-cycle, then resume from the same ID state
    #2 rst = 1'b1;
    #1;
    chk("async_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_pc", ex_pc, 32'd0);
    chk("async_stall", {31'd0, id_stall}, 32'd0);
    rst = 1'b0;
    tick();
    chk("resume_valid", {31'd0, ex_valid}, 32'd1);
    chk("resume_pc", ex_pc, 32'h100);
    // EX writes x3; ID reads x3 twice; MEM not-ready match on x3 too
    issue(32'h104, 5'd3, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
    ex_fwd_data = 32'h10; rs1_data_out = 32'h99; rs2_data_out = 32'h99;
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd_index = 5'd3; mem_data_ready = 1'b0;
    mem_fwd_data = 32'h77;
`ifdef OPF_FORWARD_EN
    chk_stall("b_stall", 1'b0);
    tick();
    chk("b_valid", {31'd0, ex_valid}, 32'd1);
    chk("b_rs1", ex_rs1_val, 32'h10);
    chk("b_rs2", ex_rs2_val, 32'h10);
    mem_valid = 1'b0;
`else
    chk_stall("b_stall", 1'b1);
    tick();
    chk("b_bubble", {31'd0, ex_valid}, 32'd0);
    chk("b_hold_pc", ex_pc, 32'h100);
    mem_valid = 1'b0;
    chk_stall("b_stall2", 1'b0);
    tick();
    chk("b_valid", {31'd0, ex_valid}, 32'd1);
    chk("b_rs1", ex_rs1_val, 32'h99);
`endif
    // load-use on x7
    do_reset();
    issue(32'h200, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    chk("c_load_valid", {31'd0, ex_valid}, 32'd1);
    chk("c_load_flag", {31'd0, ex_is_load}, 32'd1);
    issue(32'h204, 5'd7, 1'b1, 5'd7, 1'b0, 5'd8, 1'b1, 1'b0);
    chk_stall("c_stall", 1'b1);
    tick();
    chk("c_bubble", {31'd0, ex_valid}, 32'd0);
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd_index = 5'd7; mem_fwd_data = 32'hCAFEBABE;
`ifdef OPF_FORWARD_EN
    mem_data_ready = 1'b0;
    chk_stall("c_notready", 1'b1);
    tick();
    chk("c_bubble2", {31'd0, ex_valid}, 32'd0);
    mem_data_ready = 1'b1;
    chk_stall("c_ready", 1'b0);
`else
    mem_data_ready = 1'b1;
    chk_stall("c_mem_stall", 1'b1);
    tick();
    chk("c_bubble2", {31'd0, ex_valid}, 32'd0);
    mem_valid = 1'b0; wb_en = 1'b1; wb_rd_index = 5'd7; wb_data = 32'hCAFEBABE;
    chk_stall("c_wb_stall", 1'b1);
    tick();
    wb_en = 1'b0; rs1_data_out = 32'hCAFEBABE;
    chk_stall("c_ready", 1'b0);
`endif
    tick();
    chk("c_valid", {31'd0, ex_valid}, 32'd1);
    chk("c_pc", ex_pc, 32'h204);
    chk("c_rs1", ex_rs1_val, 32'hCAFEBABE);
    // WB write and ID read of x3 in the same cycle
    do_reset();
    issue(32'h300, 5'd0, 1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
    wb_en = 1'b1; wb_rd_index = 5'd3; wb_data = 32'h55;
`ifdef OPF_FORWARD_EN
    chk_stall("d_stall", 1'b0);
`else
    chk_stall("d_stall", 1'b1);
    tick();
    chk("d_bubble", {31'd0, ex_valid}, 32'd0);
    wb_en = 1'b0; rs2_data_out = 32'h55;
    chk_stall("d_stall2", 1'b0);
`endif
    tick();
    chk("d_valid", {31'd0, ex_valid}, 32'd1);
    chk("d_rs2", ex_rs2_val, 32'h55);
    // x0 is never forwarded nor stalled on
    do_reset();
    issue(32'h400, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    issue(32'h404, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    ex_fwd_data = 32'hFFFF; rs1_data_out = 32'hDEAD; rs2_data_out = 32'hBEEF;
    chk_stall("e_stall", 1'b0);
    tick();
    chk("e_valid", {31'd0, ex_valid}, 32'd1);
    chk("e_rs1", ex_rs1_val, 32'd0);
    chk("e_rs2", ex_rs2_val, 32'd0);
    // flush with a pending load-use hazard
    do_reset();
    issue(32'h500, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    issue(32'h504, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    flush = 1'b1;
    chk_stall("f_stall", 1'b0);
    tick();
    chk("f_bubble", {31'd0, ex_valid}, 32'd0);
    chk("f_hold_pc", ex_pc, 32'h500);
    chk("f_hold_rd", {27'd0, ex_rd_index}, 32'd7);
    flush = 1'b0;
    issue(32'h508, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    chk_stall("g_stall0", 1'b0);
    tick();
    chk("g_valid", {31'd0, ex_valid}, 32'd1);
    // downstream hold for three cycles
    ex_hold = 1'b1;
    issue(32'h50C, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_stall("g_hold_stall", 1'b1);
      tick();
      chk("g_hold_pc", ex_pc, 32'h508);
      chk("g_hold_valid", {31'd0, ex_valid}, 32'd1);
    end
    ex_hold = 1'b0;
    chk_stall("g_release", 1'b0);
    tick();
    chk("g_next_pc", ex_pc, 32'h50C);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
